// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT types, defaults and index bit-reversal helper
package fft_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NPTS   = 32;

  typedef logic [DEF_DATA_W-1:0] sample_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } unload_state_e;

  // Reverses the low 'width' bits of idx; bits above width come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[5'(i)] = idx[5'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pts_unloader_if.sv
// rtl/fft_pts_unloader_if.sv - frame load and serial output handshake bundle
interface fft_pts_unloader_if #(
  parameter int DATA_W = 16,
  parameter int NPTS   = 32,
  parameter int IDX_W  = $clog2(NPTS)
) ();

  logic [NPTS*DATA_W-1:0] par_in;
  logic                   load_valid;
  logic                   load_ready;
  logic                   bitrev_mode;
  logic [DATA_W-1:0]      out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic [IDX_W-1:0]       out_index;
  logic                   overrun;
  logic                   clr_overrun;

  modport master (
    output par_in, load_valid, bitrev_mode, out_ready, clr_overrun,
    input  load_ready, out_data, out_valid, out_last, out_index, overrun
  );

  modport slave (
    input  par_in, load_valid, bitrev_mode, out_ready, clr_overrun,
    output load_ready, out_data, out_valid, out_last, out_index, overrun
  );

endinterface

// File: rtl/pts_frame_buffer.sv
// rtl/pts_frame_buffer.sv - NPTS x DATA_W frame register array with natural/bit-reversed read
module pts_frame_buffer
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NPTS   = 32,
  parameter int IDX_W  = $clog2(NPTS)
) (
  input  logic                   clk,
  input  logic                   load,
  input  logic [NPTS*DATA_W-1:0] par_in,
  input  logic [IDX_W-1:0]       rd_idx,
  input  logic                   rd_bitrev,
  output logic [DATA_W-1:0]      rd_data
);

  logic [DATA_W-1:0] mem [NPTS];
  logic [IDX_W-1:0]  rd_addr;

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NPTS; k++) mem[k] <= par_in[k*DATA_W +: DATA_W];
    end
  end

  assign rd_addr = rd_bitrev ? IDX_W'(bitrev(32'(rd_idx), IDX_W)) : rd_idx;
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_pts_unloader.sv
// rtl/fft_pts_unloader.sv - parallel FFT frame to serial valid/ready stream unloader
module fft_pts_unloader
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NPTS   = DEF_NPTS
) (
  input logic                clk,
  input logic                rst,
  fft_pts_unloader_if.slave  bus
);

  localparam int IDX_W = $clog2(NPTS);
  localparam logic [0:0] S_IDLE   = IDLE;
  localparam logic [0:0] S_STREAM = STREAM;

  logic [0:0]        state;
  logic [IDX_W-1:0]  count;
  logic              bitrev_q;
  logic [DATA_W-1:0] data_q;
  logic              overrun_q;
  logic [DATA_W-1:0] next_data;
  logic              valid;
  logic              last;
  logic              beat;
  logic              load_rdy;
  logic              load_acc;

  assign valid    = (state == S_STREAM);
  assign last     = valid && (count == IDX_W'(NPTS - 1));
  assign beat     = valid && bus.out_ready;
  assign load_rdy = (state == S_IDLE) || (beat && last);
  assign load_acc = bus.load_valid && load_rdy;

  // Reads the sample for the beat after the current one, so out_data can be registered.
  pts_frame_buffer #(.DATA_W(DATA_W), .NPTS(NPTS), .IDX_W(IDX_W)) u_buf (
    .clk       (clk),
    .load      (load_acc),
    .par_in    (bus.par_in),
    .rd_idx    (IDX_W'(count + 1'b1)),
    .rd_bitrev (bitrev_q),
    .rd_data   (next_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      bitrev_q  <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      // Index 0 bit-reverses to 0, so the first beat comes straight from par_in.
      if (load_acc) begin
        state    <= S_STREAM;
        count    <= '0;
        bitrev_q <= bus.bitrev_mode;
        data_q   <= bus.par_in[DATA_W-1:0];
      end else if (beat) begin
        if (last) begin
          state <= S_IDLE;
          count <= '0;
        end else begin
          count  <= IDX_W'(count + 1'b1);
          data_q <= next_data;
        end
      end
      if (bus.load_valid && !load_rdy) overrun_q <= 1'b1;
      else if (bus.clr_overrun)        overrun_q <= 1'b0;
    end
  end

  assign bus.load_ready = load_rdy;
  assign bus.out_valid  = valid;
  assign bus.out_data   = data_q;
  assign bus.out_last   = last;
  assign bus.out_index  = count;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_fft_pts_unloader.sv
// tb/tb_fft_pts_unloader.sv - scoreboard bench for fft_pts_unloader at NPTS=8 and NPTS=32
module tb_fft_pts_unloader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_pts_unloader_if #(.DATA_W(16), .NPTS(8))  if8 ();
  fft_pts_unloader_if #(.DATA_W(16), .NPTS(32)) if32 ();

  fft_pts_unloader #(.DATA_W(16), .NPTS(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  fft_pts_unloader #(.DATA_W(16), .NPTS(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  int checks = 0;
  int errors = 0;
  int beats32 = 0;
  logic [31:0] exp8[$];
  logic [31:0] exp32[$];
  int rev8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [2:0] ready_pat = 3'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard entry packing: {last, index, data}
  logic [31:0] held8, held32;
  bit hold8 = 0, hold32 = 0;

  always @(negedge clk) begin
    if (!rst && if8.out_valid) begin
      if (hold8) check("stall_hold8", {7'd0, if8.out_last, 5'd0, if8.out_index, if8.out_data}, held8);
      if (if8.out_ready) begin
        hold8 = 0;
        if (exp8.size() == 0) check("unexpected_beat8", 32'd1, 32'd0);
        else check("beat8", {7'd0, if8.out_last, 5'd0, if8.out_index, if8.out_data}, exp8.pop_front());
      end else begin
        hold8 = 1;
        held8 = {7'd0, if8.out_last, 5'd0, if8.out_index, if8.out_data};
      end
    end else hold8 = 0;
  end

  always @(negedge clk) begin
    if (!rst && if32.out_valid) begin
      if (hold32) check("stall_hold32", {7'd0, if32.out_last, 3'd0, if32.out_index, if32.out_data}, held32);
      if (if32.out_ready) begin
        hold32 = 0;
        beats32++;
        if (exp32.size() == 0) check("unexpected_beat32", 32'd1, 32'd0);
        else check("beat32", {7'd0, if32.out_last, 3'd0, if32.out_index, if32.out_data}, exp32.pop_front());
      end else begin
        hold32 = 1;
        held32 = {7'd0, if32.out_last, 3'd0, if32.out_index, if32.out_data};
      end
    end else hold32 = 0;
  end

  // Called at posedge+1; returns at posedge+1 one cycle after the offer.
  task automatic load8(input logic [15:0] base, input bit br);
    logic [127:0] par;
    for (int k = 0; k < 8; k++) par[k*16 +: 16] = base + 16'(k);
    if8.par_in = par;
    if8.bitrev_mode = br;
    if8.load_valid = 1'b1;
    for (int i = 0; i < 8; i++)
      exp8.push_back({7'd0, (i == 7), 5'd0, 3'(i), base + 16'(br ? rev8[i] : i)});
    @(posedge clk); #1;
    if8.load_valid = 1'b0;
    if8.bitrev_mode = 1'b0;
  endtask

  task automatic wait_idx8(input int target);
    bit found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (if8.out_valid && 32'(if8.out_index) == target) found = 1;
      else begin @(posedge clk); #1; end
    end
    check("wait_index8", 32'(found), 32'd1);
  endtask

  task automatic drain8();
    bit done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      if (exp8.size() == 0 && !if8.out_valid) done = 1;
      else begin @(posedge clk); #1; end
    end
    check("drain8", 32'(done), 32'd1);
  endtask

  initial begin
    logic [511:0] par32;
    bit done;
    if8.par_in = '0;  if8.load_valid = 0;  if8.bitrev_mode = 0;  if8.out_ready = 1;  if8.clr_overrun = 0;
    if32.par_in = '0; if32.load_valid = 0; if32.bitrev_mode = 0; if32.out_ready = 0; if32.clr_overrun = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid8", 32'(if8.out_valid), 32'd0);
    check("rst_load_ready8", 32'(if8.load_ready), 32'd1);
    check("rst_overrun8", 32'(if8.overrun), 32'd0);
    check("rst_data8", 32'(if8.out_data), 32'd0);
    check("rst_last_index8", {if8.out_last, if8.out_index}, 32'd0);
    check("rst_valid32", 32'(if32.out_valid), 32'd0);
    check("rst_load_ready32", 32'(if32.load_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Natural order, one-cycle latency
    check("pre_load_valid", 32'(if8.out_valid), 32'd0);
    load8(16'h0000, 1'b0);
    check("latency_valid", 32'(if8.out_valid), 32'd1);
    check("first_data", 32'(if8.out_data), 32'h0000);
    drain8();

    // Bit-reversed order
    load8(16'h0000, 1'b1);
    drain8();

    // Backpressure on the 32-point instance
    for (int k = 0; k < 32; k++) begin
      par32[k*16 +: 16] = 16'h1000 + 16'(k);
      exp32.push_back({7'd0, (k == 31), 3'd0, 5'(k), 16'h1000 + 16'(k)});
    end
    if32.par_in = par32;
    if32.out_ready = 1'b1;
    if32.load_valid = 1'b1;
    @(posedge clk); #1;
    if32.load_valid = 1'b0;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (exp32.size() == 0 && !if32.out_valid) done = 1;
      else begin
        ready_pat = 3'(n % 4);
        if32.out_ready = (ready_pat == 0 || ready_pat == 3);
        @(posedge clk); #1;
      end
    end
    check("drain32", 32'(done), 32'd1);
    check("beats32", 32'(beats32), 32'd32);

    // Back-to-back frames without a bubble
    load8(16'h00A0, 1'b0);
    wait_idx8(7);
    check("b2b_load_ready", 32'(if8.load_ready), 32'd1);
    load8(16'h00B0, 1'b0);
    check("b2b_valid", 32'(if8.out_valid), 32'd1);
    check("b2b_first", {15'd0, if8.out_index, if8.out_data}, 32'h0000_00B0);
    drain8();
    check("b2b_no_overrun", 32'(if8.overrun), 32'd0);

    // Overrun while streaming
    load8(16'h00C0, 1'b0);
    wait_idx8(3);
    if8.par_in = '1;
    if8.load_valid = 1'b1;
    @(posedge clk); #1;
    if8.load_valid = 1'b0;
    check("overrun_set", 32'(if8.overrun), 32'd1);
    drain8();
    if8.clr_overrun = 1'b1;
    @(posedge clk); #1;
    if8.clr_overrun = 1'b0;
    check("overrun_clr", 32'(if8.overrun), 32'd0);
    load8(16'h00D0, 1'b1);
    if8.par_in = '1;
    if8.load_valid = 1'b1;
    if8.clr_overrun = 1'b1;
    @(posedge clk); #1;
    if8.load_valid = 1'b0;
    if8.clr_overrun = 1'b0;
    check("overrun_set_wins", 32'(if8.overrun), 32'd1);
    drain8();

    // Reset mid-frame at beat 5
    load8(16'h0050, 1'b0);
    wait_idx8(5);
    if8.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp8.delete();
    check("midrst_valid", 32'(if8.out_valid), 32'd0);
    check("midrst_load_ready", 32'(if8.load_ready), 32'd1);
    check("midrst_overrun", 32'(if8.overrun), 32'd0);
    if8.out_ready = 1'b1;
    load8(16'h0060, 1'b1);
    drain8();
    check("queue8_empty", 32'(exp8.size()), 32'd0);
    check("queue32_empty", 32'(exp32.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
